memaccess_hs: RTL and testbench
===============================

Name: memaccess_hs

Overview:
- Parametrised next-generation DLX MEM stage (IR4->IR5).
- Adds to the plain MEM stage:
  - a req/ack data-memory handshake with wait states and pipeline stall
  - byte-lane alignment and write byte-enables for SB/SH/SW
  - correct two's-complement sign extension for LB/LH
  - misalignment detection and access timeout
  - selectable little/big-endian lane mapping
- Sits between the EX stage (alu_in4/bin4/inst_in4) and WB; drives the external data memory port.

Parameters:
- BIG_ENDIAN, 0, 0 = byte lane addr[1:0]; 1 = lane 3-addr[1:0], halfword lanes swapped.
- ALIGN_CHECK, 1, 1 = flag misaligned LH/LHU/SH/LW/SW and suppress access; 0 = force offending low address bits to zero and perform the access.
- TIMEOUT_CYC, 16, max ACCESS cycles without mem_ack before abort (range 1..255).

Ports:
- clock4  in  1  stage clock, all state on rising edge
- reset4  in  1  synchronous, active-high reset
- valid_in4  in  1  inst_in4/alu_in4/bin4 hold a live instruction
- inst_in4  in  32  instruction from EX; opcode = [31:26]
- alu_in4  in  32  effective address / ALU result
- bin4  in  32  store data (register B)
- stall_out4  out  1  combinational; high while state=ACCESS; upstream must hold inputs
- mem_req  out  1  registered memory request
- mem_we  out  1  registered; 1 = write
- mem_be  out  4  registered byte enables, bit i = byte [8i+7:8i]
- mem_addr  out  32  registered word address, {alu[31:2],2'b00}
- mem_wdata  out  32  registered, lane-replicated store data
- mem_rdata  in  32  read data, valid in the mem_ack cycle
- mem_ack  in  1  access complete (one-cycle pulse)
- inst_out4  out  32  IR5
- alu_out4  out  32  ALU result to WB
- loadmemdata_out  out  32  extended load data
- valid_out4  out  1  outputs hold a retired instruction this cycle
- misalign_err  out  1  one-cycle pulse, aligned with valid_out4
- timeout_err  out  1  one-cycle pulse, aligned with valid_out4

Behaviour:
- Clock and reset:
  - One clock (clock4).
  - Reset is synchronous and active-high (reset4).
  - Reset values: every registered output 0; FSM state = IDLE; timeout counter 0.
- Opcodes:
  - Loads: LB=000001, LBU=000010, LH=000011, LHU=000100, LW=000101.
  - Stores: SB=001000, SH=001001, SW=001010.
  - All other opcodes are non-memory.
- FSM has two states: IDLE and ACCESS.
- IDLE:
  - Inputs are accepted whenever valid_in4=1.
  - Non-memory op: next edge inst_out4<=inst_in4, alu_out4<=alu_in4, loadmemdata_out<=0, valid_out4<=1. Latency 1.
  - valid_in4=0: next edge valid_out4<=0, inst_out4<=0 (NOP bubble).
  - Aligned memory op: next edge mem_req<=1 and mem_addr/mem_we/mem_be/mem_wdata are loaded; inst/alu captured internally; valid_out4<=0; state->ACCESS; counter<=1.
  - Misaligned op with ALIGN_CHECK=1: no access; one-cycle pass-through with loadmemdata_out=0 and misalign_err=1.
  - Misalignment means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- ACCESS:
  - stall_out4=1; mem_* outputs held stable.
  - On mem_ack=1: next edge mem_req<=0; outputs <= captured inst/alu, loadmemdata_out <= extracted data (0 for stores); valid_out4<=1; state->IDLE.
  - Minimum latency acceptance->valid_out4 is 2 cycles.
  - No ack while counter==TIMEOUT_CYC: next edge abort, i.e. mem_req<=0, valid_out4<=1, loadmemdata_out<=0, timeout_err<=1, state->IDLE.
  - Otherwise counter increments.
- Load extraction (lane L as selected by BIG_ENDIAN):
  - LB: sign-extend byte L.
  - LBU: zero-extend byte L.
  - LH: sign-extend halfword (addr[1]? upper:lower, mirrored when BIG_ENDIAN).
  - LHU: zero-extend the same halfword.
  - LW: mem_rdata unchanged.
- Stores:
  - SB: wdata={4{bin4[7:0]}}, be=1<<L.
  - SH: wdata={2{bin4[15:0]}}, be=4'b0011 or 4'b1100 (per addr[1] and endianness).
  - SW: wdata=bin4, be=4'b1111.
  - Loads: be=4'b1111, mem_we=0.
- Boundaries:
  - mem_ack in IDLE is ignored.
  - valid_in4 changes during ACCESS are ignored.
  - Reset during ACCESS: mem_req=0 next edge; an ack arriving after reset is ignored.
  - The back-to-back memory op following an ack is accepted on the cycle stall_out4 falls.

Test Plan:
- LB, addr 0x1003, rdata 0x80FF_7F01, LE, ack after 0 waits -> loadmemdata_out=0xFFFF_FF80, valid_out4 two cycles after acceptance; same with BIG_ENDIAN=1 -> 0x0000_0001.
- SH, addr 0x2002, bin4=0x1234_ABCD -> mem_we=1, mem_be=4'b1100, mem_wdata=0xABCD_ABCD, mem_addr=0x2000; 3 wait cycles -> stall_out4 high exactly 4 cycles.
- LW, addr 0x0001, ALIGN_CHECK=1 -> mem_req never asserts, misalign_err=1, loadmemdata_out=0, latency 1; with ALIGN_CHECK=0 -> access at 0x0000.
- LHU, addr 0x0002, no ack, TIMEOUT_CYC=4 -> mem_req high 4 cycles, then timeout_err=1, valid_out4=1, loadmemdata_out=0.
- ADD, then LH (rdata 0x0000_8001), then NOP back-to-back -> ADD retires at latency 1; LH retires with 0xFFFF_8001; no lost or duplicated valid_out4.
- reset4 asserted in the 2nd ACCESS cycle, ack one cycle later -> all outputs 0, FSM IDLE, no valid_out4 pulse.

Source files
------------

// File: rtl/memaccess_hs_if.sv
// Data-memory port of the DLX MEM stage: a req/ack handshake with wait states.
interface memaccess_hs_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memaccess_hs.sv
// DLX MEM stage (IR4->IR5) with a handshaked data memory, byte lanes, sign
// extension, misalignment detection and access timeout.
module memaccess_hs #(
  parameter bit          BIG_ENDIAN  = 1'b0,
  parameter bit          ALIGN_CHECK = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic           clock4,
  input  logic           reset4,
  input  logic           valid_in4,
  input  logic [31:0]    inst_in4,
  input  logic [31:0]    alu_in4,
  input  logic [31:0]    bin4,
  output logic           stall_out4,
  memaccess_hs_if.master mem,
  output logic [31:0]    inst_out4,
  output logic [31:0]    alu_out4,
  output logic [31:0]    loadmemdata_out,
  output logic           valid_out4,
  output logic           misalign_err,
  output logic           timeout_err
);
  localparam logic [5:0] OP_LB = 6'b000001, OP_LBU = 6'b000010, OP_LH = 6'b000011,
                         OP_LHU = 6'b000100, OP_LW = 6'b000101,
                         OP_SB = 6'b001000, OP_SH = 6'b001001, OP_SW = 6'b001010;
  localparam logic [7:0] TO_CYC = 8'(TIMEOUT_CYC);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] inst_q, alu_q;
  logic [1:0]  lo_q;

  logic [5:0]  op_in;
  logic        is_ld, is_st, is_half, is_word, is_byte, mis_d;
  logic [1:0]  lo_d, lane_d, lane_r;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_d;
  logic [7:0]  byte_r;
  logic [15:0] half_r;

  assign stall_out4 = (state_q == ACCESS);

  always_comb begin
    op_in   = inst_in4[31:26];
    is_ld   = op_in inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    is_st   = op_in inside {OP_SB, OP_SH, OP_SW};
    is_half = op_in inside {OP_LH, OP_LHU, OP_SH};
    is_word = op_in inside {OP_LW, OP_SW};
    is_byte = op_in inside {OP_LB, OP_LBU, OP_SB};
    mis_d   = (is_half && alu_in4[0]) || (is_word && (alu_in4[1:0] != 2'b00));
    // Without the check, misaligned accesses are squashed onto the natural boundary.
    lo_d = alu_in4[1:0];
    if (!ALIGN_CHECK) begin
      if (is_half) lo_d[0] = 1'b0;
      if (is_word) lo_d    = 2'b00;
    end
    lane_d  = BIG_ENDIAN ? (2'd3 - lo_d) : lo_d;
    be_d    = 4'b1111;
    wdata_d = bin4;
    if (is_st && is_byte) begin
      be_d    = 4'b0001 << lane_d;
      wdata_d = {4{bin4[7:0]}};
    end else if (is_st && is_half) begin
      be_d    = (lo_d[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
      wdata_d = {2{bin4[15:0]}};
    end
  end

  always_comb begin
    lane_r = BIG_ENDIAN ? (2'd3 - lo_q) : lo_q;
    byte_r = mem.mem_rdata[{lane_r, 3'b000} +: 8];
    half_r = (lo_q[1] ^ BIG_ENDIAN) ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    ld_d   = 32'd0;
    case (inst_q[31:26])
      OP_LB:   ld_d = {{24{byte_r[7]}}, byte_r};
      OP_LBU:  ld_d = {24'd0, byte_r};
      OP_LH:   ld_d = {{16{half_r[15]}}, half_r};
      OP_LHU:  ld_d = {16'd0, half_r};
      OP_LW:   ld_d = mem.mem_rdata;
      default: ld_d = 32'd0;
    endcase
  end

  always_ff @(posedge clock4) begin
    if (reset4) begin
      state_q         <= IDLE;
      cnt_q           <= 8'd0;
      inst_q          <= 32'd0;
      alu_q           <= 32'd0;
      lo_q            <= 2'd0;
      mem.mem_req     <= 1'b0;
      mem.mem_we      <= 1'b0;
      mem.mem_be      <= 4'd0;
      mem.mem_addr    <= 32'd0;
      mem.mem_wdata   <= 32'd0;
      inst_out4       <= 32'd0;
      alu_out4        <= 32'd0;
      loadmemdata_out <= 32'd0;
      valid_out4      <= 1'b0;
      misalign_err    <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!valid_in4) begin
            valid_out4      <= 1'b0;
            inst_out4       <= 32'd0;
            loadmemdata_out <= 32'd0;
          end else if (!(is_ld || is_st) || (ALIGN_CHECK && mis_d)) begin
            inst_out4       <= inst_in4;
            alu_out4        <= alu_in4;
            loadmemdata_out <= 32'd0;
            valid_out4      <= 1'b1;
            misalign_err    <= (is_ld || is_st) && mis_d;
          end else begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_st;
            mem.mem_be    <= be_d;
            mem.mem_addr  <= {alu_in4[31:2], 2'b00};
            mem.mem_wdata <= wdata_d;
            inst_q        <= inst_in4;
            alu_q         <= alu_in4;
            lo_q          <= lo_d;
            valid_out4    <= 1'b0;
            cnt_q         <= 8'd1;
            state_q       <= ACCESS;
          end
        end
        ACCESS: begin
          // An ack in the final allowed cycle still completes the access.
          if (mem.mem_ack || (cnt_q == TO_CYC)) begin
            mem.mem_req     <= 1'b0;
            inst_out4       <= inst_q;
            alu_out4        <= alu_q;
            loadmemdata_out <= mem.mem_ack ? ld_d : 32'd0;
            valid_out4      <= 1'b1;
            timeout_err     <= !mem.mem_ack;
            state_q         <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memaccess_hs.sv
// Directed bench for memaccess_hs: a little-endian/checked and a big-endian/unchecked
// instance run in lockstep; retirements are matched against a per-instance queue.
module tb_memaccess_hs;
  localparam logic [5:0] LB = 6'b000001, LBU = 6'b000010, LH = 6'b000011, LHU = 6'b000100,
                         LW = 6'b000101, SB = 6'b001000, SH = 6'b001001, SW = 6'b001010,
                         ADD = 6'b000000, NOP = 6'b010101;

  typedef struct {
    logic [31:0] inst, alu, data;
    logic        merr, terr;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, vin = 1'b0, ack = 1'b0;
  logic [31:0] inst = '0, alu = '0, bin = '0, rdata = '0;
  logic        st0, st1, v0, v1, me0, me1, te0, te1;
  logic [31:0] io0, io1, ao0, ao1, ld0, ld1;
  int          checks = 0, errors = 0;
  exp_t        q0[$], q1[$];

  memaccess_hs_if if0();
  memaccess_hs_if if1();
  assign if0.mem_rdata = rdata;
  assign if0.mem_ack   = ack;
  assign if1.mem_rdata = rdata;
  assign if1.mem_ack   = ack;

  memaccess_hs #(.BIG_ENDIAN(1'b0), .ALIGN_CHECK(1'b1), .TIMEOUT_CYC(4)) dut0 (
    .clock4(clk), .reset4(rst), .valid_in4(vin), .inst_in4(inst), .alu_in4(alu), .bin4(bin),
    .stall_out4(st0), .mem(if0), .inst_out4(io0), .alu_out4(ao0), .loadmemdata_out(ld0),
    .valid_out4(v0), .misalign_err(me0), .timeout_err(te0));

  memaccess_hs #(.BIG_ENDIAN(1'b1), .ALIGN_CHECK(1'b0), .TIMEOUT_CYC(4)) dut1 (
    .clock4(clk), .reset4(rst), .valid_in4(vin), .inst_in4(inst), .alu_in4(alu), .bin4(bin),
    .stall_out4(st1), .mem(if1), .inst_out4(io1), .alu_out4(ao1), .loadmemdata_out(ld1),
    .valid_out4(v1), .misalign_err(me1), .timeout_err(te1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference extraction: shift the addressed lane down, then extend.
  function automatic logic [31:0] model_ld(input logic [5:0] op, input logic [1:0] a,
                                           input logic [31:0] rd, input bit be);
    int sh;
    logic [31:0] s;
    if (op == LB || op == LBU) sh = be ? 8 * (3 - int'(a)) : 8 * int'(a);
    else                       sh = be ? 16 * (1 - int'(a[1])) : 16 * int'(a[1]);
    s = rd >> sh;
    case (op)
      LB:      return {{24{s[7]}}, s[7:0]};
      LBU:     return {24'd0, s[7:0]};
      LH:      return {{16{s[15]}}, s[15:0]};
      LHU:     return {16'd0, s[15:0]};
      LW:      return rd;
      default: return 32'd0;
    endcase
  endfunction

  task automatic retire(input int id, input logic v, input logic [31:0] io, ao, ld,
                        input logic me, te);
    exp_t e;
    int   n;
    if (v !== 1'b1) return;
    n = (id == 0) ? q0.size() : q1.size();
    checks++;
    assert (n != 0) else begin
      errors++;
      $error("FAIL d%0d_extra_valid: got valid_out4=1 expected no retirement", id);
    end
    if (n == 0) return;
    if (id == 0) e = q0.pop_front();
    else         e = q1.pop_front();
    chk($sformatf("d%0d_inst", id), io, e.inst);
    chk($sformatf("d%0d_alu", id), ao, e.alu);
    chk($sformatf("d%0d_ldata", id), ld, e.data);
    chk($sformatf("d%0d_merr", id), {31'd0, me}, {31'd0, e.merr});
    chk($sformatf("d%0d_terr", id), {31'd0, te}, {31'd0, e.terr});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    retire(0, v0, io0, ao0, ld0, me0, te0);
    retire(1, v1, io1, ao1, ld1, me1, te1);
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    vin  = 1'b1;
    inst = {op, 5'd1, 5'd2, 16'h0abc};
    alu  = a;
    bin  = b;
  endtask

  task automatic push(input int id, input logic [31:0] d, input logic me, input logic te);
    exp_t e;
    e.inst = inst; e.alu = alu; e.data = d; e.merr = me; e.terr = te;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  initial begin
    int sc, rc;
    // Reset state
    tick(); tick();
    chk("rst_valid", {31'd0, v0}, 32'd0);
    chk("rst_req", {31'd0, if0.mem_req}, 32'd0);
    chk("rst_stall", {31'd0, st0}, 32'd0);
    chk("rst_inst", io0, 32'd0);
    chk("rst_addr", if1.mem_addr, 32'd0);
    rst = 1'b0;

    // LB at 0x1003, zero wait states
    issue(LB, 32'h1003, 32'd0);
    push(0, 32'hFFFF_FF80, 1'b0, 1'b0);
    push(1, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    vin = 1'b0;
    chk("lb_req", {31'd0, if0.mem_req}, 32'd1);
    chk("lb_addr", if0.mem_addr, 32'h1000);
    chk("lb_be", {28'd0, if0.mem_be}, 32'hF);
    chk("lb_we", {31'd0, if0.mem_we}, 32'd0);
    chk("lb_stall", {31'd0, st0}, 32'd1);
    chk("lb_early", {31'd0, v0}, 32'd0);
    ack = 1'b1; rdata = 32'h80FF_7F01;
    tick();
    ack = 1'b0;
    chk("lb_lat0", {31'd0, v0}, 32'd1);
    chk("lb_lat1", {31'd0, v1}, 32'd1);
    chk("lb_reqoff", {31'd0, if0.mem_req}, 32'd0);

    // SH at 0x2002 with 3 wait states; the ack lands in the last allowed cycle
    issue(SH, 32'h2002, 32'h1234_ABCD);
    push(0, 32'd0, 1'b0, 1'b0);
    push(1, 32'd0, 1'b0, 1'b0);
    tick();
    vin = 1'b0;
    chk("sh_we", {31'd0, if0.mem_we}, 32'd1);
    chk("sh_be0", {28'd0, if0.mem_be}, 32'hC);
    chk("sh_be1", {28'd0, if1.mem_be}, 32'h3);
    chk("sh_wdata", if0.mem_wdata, 32'hABCD_ABCD);
    chk("sh_addr", if0.mem_addr, 32'h2000);
    sc = 0;
    for (int i = 0; i < 10; i++) begin
      if (st0 !== 1'b1) break;
      sc++;
      chk("sh_hold_be", {28'd0, if0.mem_be}, 32'hC);
      if (sc == 4) ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    chk("sh_stall_cycles", sc, 32'd4);
    chk("sh_noto", {31'd0, te0}, 32'd0);

    // LW at 0x0001: checked instance flags it, unchecked one accesses word 0
    issue(LW, 32'h0000_0001, 32'd0);
    push(0, 32'd0, 1'b1, 1'b0);
    push(1, 32'hCAFE_F00D, 1'b0, 1'b0);
    tick();
    vin = 1'b0;
    chk("mis_lat", {31'd0, v0}, 32'd1);
    chk("mis_noreq", {31'd0, if0.mem_req}, 32'd0);
    chk("mis_req1", {31'd0, if1.mem_req}, 32'd1);
    chk("mis_addr1", if1.mem_addr, 32'h0000_0000);
    ack = 1'b1; rdata = 32'hCAFE_F00D;
    tick();
    ack = 1'b0;
    chk("idle_ack_ignored", {31'd0, v0}, 32'd0);
    chk("idle_ack_noreq", {31'd0, if0.mem_req}, 32'd0);

    // LHU at 0x0002 with no ack: aborts after 4 request cycles
    issue(LHU, 32'h0000_0002, 32'd0);
    push(0, 32'd0, 1'b0, 1'b1);
    push(1, 32'd0, 1'b0, 1'b1);
    tick();
    vin = 1'b0;
    rc = 0;
    for (int i = 0; i < 10; i++) begin
      if (if0.mem_req !== 1'b1) break;
      rc++;
      tick();
    end
    chk("to_req_cycles", rc, 32'd4);
    chk("to_valid", {31'd0, v0}, 32'd1);

    // ADD, LH, NOP back to back; NOP is held while the stage stalls
    issue(ADD, 32'h0000_0011, 32'd0);
    push(0, 32'h0000_0011 & 32'd0, 1'b0, 1'b0);
    push(1, 32'd0, 1'b0, 1'b0);
    tick();
    chk("add_lat", {31'd0, v0}, 32'd1);
    issue(LH, 32'h0000_0000, 32'd0);
    push(0, 32'hFFFF_8001, 1'b0, 1'b0);
    push(1, model_ld(LH, 2'd0, 32'h0000_8001, 1'b1), 1'b0, 1'b0);
    tick();
    issue(NOP, 32'h0000_0055, 32'd0);
    push(0, 32'd0, 1'b0, 1'b0);
    push(1, 32'd0, 1'b0, 1'b0);
    chk("b2b_stall", {31'd0, st0}, 32'd1);
    ack = 1'b1; rdata = 32'h0000_8001;
    tick();
    ack = 1'b0;
    chk("b2b_stall_fall", {31'd0, st0}, 32'd0);
    tick();
    vin = 1'b0;
    chk("nop_ret", {31'd0, v0}, 32'd1);
    tick();
    chk("bubble", {31'd0, v0}, 32'd0);

    // SB at 0x0301 and LBU at 0x0302 through both lane maps
    issue(SB, 32'h0000_0301, 32'h0000_00A5);
    push(0, 32'd0, 1'b0, 1'b0);
    push(1, 32'd0, 1'b0, 1'b0);
    tick();
    vin = 1'b0;
    chk("sb_be0", {28'd0, if0.mem_be}, 32'h2);
    chk("sb_be1", {28'd0, if1.mem_be}, 32'h4);
    chk("sb_wdata", if1.mem_wdata, 32'hA5A5_A5A5);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    issue(LBU, 32'h0000_0302, 32'd0);
    push(0, model_ld(LBU, 2'd2, 32'h1188_F233, 1'b0), 1'b0, 1'b0);
    push(1, model_ld(LBU, 2'd2, 32'h1188_F233, 1'b1), 1'b0, 1'b0);
    tick();
    vin = 1'b0;
    ack = 1'b1; rdata = 32'h1188_F233;
    tick();
    ack = 1'b0;
    tick();

    // Reset in the 2nd ACCESS cycle, ack one cycle later
    issue(LW, 32'h0000_0040, 32'd0);
    tick();
    vin = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_acc_req", {31'd0, if0.mem_req}, 32'd0);
    chk("rst_acc_stall", {31'd0, st0}, 32'd0);
    chk("rst_acc_valid", {31'd0, v0}, 32'd0);
    chk("rst_acc_ld", ld0, 32'd0);
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    ack = 1'b0;
    chk("rst_late_ack0", {31'd0, v0}, 32'd0);
    chk("rst_late_ack1", {31'd0, v1}, 32'd0);
    chk("rst_late_req", {31'd0, if1.mem_req}, 32'd0);
    tick();

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
